// File: rtl/sprite_compositor.sv
// Sprite compositor: layers wall, snake head, body segments and apple
// sprites over a grass background with a white border, for each VGA pixel.
//
// Ports:
//   clk, rst            pixel clock, asynchronous active-high reset
//   pix_valid           curr_x/curr_y carry a pixel this cycle
//   curr_x, curr_y      pixel coordinate
//   frame_start         one-cycle pulse per frame; advances mode FSM
//   snakepos_x/_y       packed segment positions, segment 0 = head
//   length              live segment count (clamped to NUM_SEG)
//   applepos_x/_y       apple top-left
//   wallpos_x/_y        wall top-left
//   lose, win           game status, sampled on frame_start
//   spr_addr            {layer, offset} to the shared sprite ROM
//   spr_pixel           sprite ROM data, ROM_LAT cycles after spr_addr
//   grass_addr          grass ROM address
//   grass_pixel         grass ROM data, ROM_LAT cycles after grass_addr
//   draw_r/g/b          output colour
//   draw_valid          draw_* carry the pixel presented ROM_LAT+2 cycles earlier
module sprite_compositor #(
    parameter int          NUM_SEG    = 23,
    parameter int          COORD_W    = 11,
    parameter int          BLK        = 32,
    parameter int          ROM_LAT    = 1,
    parameter int          SCREEN_W   = 1440,
    parameter int          SCREEN_H   = 900,
    parameter int          BORDER     = 16,
    parameter logic [11:0] KEY        = 12'h000,
    parameter int          BLINK_LOG2 = 4,
    localparam int LEN_W = $clog2(NUM_SEG + 1),
    localparam int LB    = $clog2(BLK),
    localparam int SA_W  = 2 + 2 * LB,
    localparam int GA_W  = $clog2(SCREEN_W * SCREEN_H)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pix_valid,
    input  logic [COORD_W-1:0]         curr_x,
    input  logic [COORD_W-1:0]         curr_y,
    input  logic                       frame_start,
    input  logic [NUM_SEG*COORD_W-1:0] snakepos_x,
    input  logic [NUM_SEG*COORD_W-1:0] snakepos_y,
    input  logic [LEN_W-1:0]           length,
    input  logic [COORD_W-1:0]         applepos_x,
    input  logic [COORD_W-1:0]         applepos_y,
    input  logic [COORD_W-1:0]         wallpos_x,
    input  logic [COORD_W-1:0]         wallpos_y,
    input  logic                       lose,
    input  logic                       win,
    output logic [SA_W-1:0]            spr_addr,
    input  logic [11:0]                spr_pixel,
    output logic [GA_W-1:0]            grass_addr,
    input  logic [11:0]                grass_pixel,
    output logic [3:0]                 draw_r,
    output logic [3:0]                 draw_g,
    output logic [3:0]                 draw_b,
    output logic                       draw_valid
);

    localparam logic [COORD_W:0] C_BLK  = (COORD_W+1)'(BLK);
    localparam logic [COORD_W:0] C_BRD  = (COORD_W+1)'(BORDER);
    localparam logic [COORD_W:0] C_SW   = (COORD_W+1)'(SCREEN_W);
    localparam logic [COORD_W:0] C_SH   = (COORD_W+1)'(SCREEN_H);
    localparam logic [COORD_W:0] C_SWB  = (COORD_W+1)'(SCREEN_W - BORDER);
    localparam logic [COORD_W:0] C_SHB  = (COORD_W+1)'(SCREEN_H - BORDER);
    localparam logic [LEN_W-1:0] C_NSEG = LEN_W'(NUM_SEG);

    typedef enum logic [1:0] {
        M_PLAY = 2'd0,
        M_WIN  = 2'd1,
        M_LOSE = 2'd2
    } mode_t;

    typedef struct packed {
        logic  valid;
        logic  hit;
        logic  border;
        logic  off;
        mode_t mode;
        logic  blink;
    } pkt_t;

    // One extra bit keeps pos+BLK from wrapping at the top of the range.
    function automatic logic f_hit(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input logic [COORD_W-1:0] px,
        input logic [COORD_W-1:0] py
    );
        logic [COORD_W:0] ex;
        logic [COORD_W:0] ey;
        ex = {1'b0, px} + C_BLK;
        ey = {1'b0, py} + C_BLK;
        return (x >= px) && ({1'b0, x} < ex) &&
               (y >= py) && ({1'b0, y} < ey);
    endfunction

    mode_t                r_mode;
    mode_t                w_mode_nxt;
    logic [COORD_W-1:0]   r_frame_cnt;
    logic [COORD_W-1:0]   w_cnt_nxt;

    logic [LEN_W-1:0]     w_len;
    logic                 w_hit;
    logic [1:0]           w_layer;
    logic [COORD_W-1:0]   w_px;
    logic [COORD_W-1:0]   w_py;
    logic [LB-1:0]        w_dx;
    logic [LB-1:0]        w_dy;
    logic [GA_W-1:0]      w_gaddr;
    logic                 w_border;
    logic                 w_off;

    pkt_t                 r_s0;
    pkt_t                 r_dl [ROM_LAT];
    pkt_t                 w_fin;
    logic [SA_W-1:0]      r_saddr;
    logic [GA_W-1:0]      r_gaddr;
    logic [11:0]          w_col;
    logic [11:0]          r_col;
    logic                 r_draw_valid;

    // Mode FSM and frame counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode      <= M_PLAY;
            r_frame_cnt <= '0;
        end else begin
            r_mode      <= w_mode_nxt;
            r_frame_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_mode_nxt = r_mode;
        w_cnt_nxt  = r_frame_cnt;
        if (frame_start) begin
            if (lose)
                w_mode_nxt = M_LOSE;
            else if (win)
                w_mode_nxt = M_WIN;
            else
                w_mode_nxt = M_PLAY;
            // Blink phase restarts on entry so the lose screen opens on grass.
            if (lose && r_mode != M_LOSE)
                w_cnt_nxt = '0;
            else
                w_cnt_nxt = r_frame_cnt + 1'b1;
        end
    end

    // Layer selection
    assign w_len = (length > C_NSEG) ? C_NSEG : length;

    always_comb begin
        w_hit   = 1'b0;
        w_layer = 2'd0;
        w_px    = wallpos_x;
        w_py    = wallpos_y;
        if (f_hit(curr_x, curr_y, wallpos_x, wallpos_y)) begin
            w_hit = 1'b1;
        end else if (w_len != '0 &&
                     f_hit(curr_x, curr_y, snakepos_x[0 +: COORD_W],
                           snakepos_y[0 +: COORD_W])) begin
            w_hit   = 1'b1;
            w_layer = 2'd1;
            w_px    = snakepos_x[0 +: COORD_W];
            w_py    = snakepos_y[0 +: COORD_W];
        end else begin
            // Descending scan: the lowest matching index is assigned last.
            for (int i = NUM_SEG - 1; i >= 1; i--) begin
                if (LEN_W'(i) < w_len &&
                    f_hit(curr_x, curr_y, snakepos_x[i*COORD_W +: COORD_W],
                          snakepos_y[i*COORD_W +: COORD_W])) begin
                    w_hit   = 1'b1;
                    w_layer = 2'd2;
                    w_px    = snakepos_x[i*COORD_W +: COORD_W];
                    w_py    = snakepos_y[i*COORD_W +: COORD_W];
                end
            end
            if (!w_hit && f_hit(curr_x, curr_y, applepos_x, applepos_y)) begin
                w_hit   = 1'b1;
                w_layer = 2'd3;
                w_px    = applepos_x;
                w_py    = applepos_y;
            end
        end
    end

    // Offsets are below BLK inside a hit, so (dy*BLK + dx) is a bit concat.
    assign w_dx    = curr_x[LB-1:0] - w_px[LB-1:0];
    assign w_dy    = curr_y[LB-1:0] - w_py[LB-1:0];
    assign w_gaddr = GA_W'(curr_x) + GA_W'(curr_y) * GA_W'(SCREEN_W);

    assign w_off    = ({1'b0, curr_x} >= C_SW) || ({1'b0, curr_y} >= C_SH);
    assign w_border = ({1'b0, curr_x} <  C_BRD) || ({1'b0, curr_x} >= C_SWB) ||
                      ({1'b0, curr_y} <  C_BRD) || ({1'b0, curr_y} >= C_SHB);

    // Stage 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0    <= '0;
            r_saddr <= '0;
            r_gaddr <= '0;
        end else begin
            r_s0.valid <= pix_valid;
            if (pix_valid) begin
                r_s0.hit    <= w_hit;
                r_s0.border <= w_border;
                r_s0.off    <= w_off;
                r_s0.mode   <= r_mode;
                r_s0.blink  <= r_frame_cnt[BLINK_LOG2];
                r_gaddr     <= w_gaddr;
                if (w_hit)
                    r_saddr <= {w_layer, w_dy, w_dx};
            end
        end
    end

    assign spr_addr   = r_saddr;
    assign grass_addr = r_gaddr;

    // Delay line matched to ROM latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROM_LAT; i++)
                r_dl[i] <= '0;
        end else begin
            r_dl[0] <= r_s0;
            for (int i = 1; i < ROM_LAT; i++)
                r_dl[i] <= r_dl[i-1];
        end
    end

    assign w_fin = r_dl[ROM_LAT-1];

    // Final colour select
    always_comb begin
        w_col = grass_pixel;
        if (w_fin.off)
            w_col = 12'h000;
        else if (w_fin.mode == M_WIN)
            w_col = 12'h0F0;
        else if (w_fin.mode == M_LOSE)
            w_col = w_fin.blink ? 12'hF00 : grass_pixel;
        else if (w_fin.border)
            w_col = 12'hFFF;
        else if (w_fin.hit && spr_pixel != KEY)
            w_col = spr_pixel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_draw_valid <= 1'b0;
            r_col        <= '0;
        end else begin
            r_draw_valid <= w_fin.valid;
            if (w_fin.valid)
                r_col <= w_col;
        end
    end

    assign draw_valid = r_draw_valid;
    assign draw_r     = r_col[11:8];
    assign draw_g     = r_col[7:4];
    assign draw_b     = r_col[3:0];

endmodule

// File: tb/tb_sprite_compositor.sv
// Testbench for sprite_compositor: randomized and directed pixels checked
// through a scoreboard against a behavioural layer/mode model.
module tb_sprite_compositor;

    localparam int NSEG = 23;
    localparam int CW   = 11;
    localparam int LW   = 5;
    localparam int LAT  = 3;
    localparam int L    = LAT + 2;
    localparam int SAW  = 12;
    localparam int GAW  = 21;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 pix_valid = 1'b0;
    logic [CW-1:0]        curr_x = '0;
    logic [CW-1:0]        curr_y = '0;
    logic                 frame_start = 1'b0;
    logic [NSEG*CW-1:0]   snakepos_x = '0;
    logic [NSEG*CW-1:0]   snakepos_y = '0;
    logic [LW-1:0]        length = '0;
    logic [CW-1:0]        applepos_x = '0;
    logic [CW-1:0]        applepos_y = '0;
    logic [CW-1:0]        wallpos_x = '0;
    logic [CW-1:0]        wallpos_y = '0;
    logic                 lose = 1'b0;
    logic                 win = 1'b0;
    logic [SAW-1:0]       spr_addr;
    logic [11:0]          spr_pixel;
    logic [GAW-1:0]       grass_addr;
    logic [11:0]          grass_pixel;
    logic [3:0]           draw_r, draw_g, draw_b;
    logic                 draw_valid;

    always #5 clk = ~clk;

    sprite_compositor #(.ROM_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid),
        .curr_x(curr_x), .curr_y(curr_y), .frame_start(frame_start),
        .snakepos_x(snakepos_x), .snakepos_y(snakepos_y), .length(length),
        .applepos_x(applepos_x), .applepos_y(applepos_y),
        .wallpos_x(wallpos_x), .wallpos_y(wallpos_y),
        .lose(lose), .win(win),
        .spr_addr(spr_addr), .spr_pixel(spr_pixel),
        .grass_addr(grass_addr), .grass_pixel(grass_pixel),
        .draw_r(draw_r), .draw_g(draw_g), .draw_b(draw_b),
        .draw_valid(draw_valid)
    );

    // ROM contents as plain functions of the address
    function automatic logic [11:0] spr_f(input int a);
        if (a == 168) return 12'h5A3;
        if (a == 3397) return 12'h000;
        if (a % 7 == 0) return 12'h000;
        return 12'(((a * 37 + 291) % 4095) + 1);
    endfunction

    function automatic logic [11:0] grass_f(input int a);
        if (a == 302605) return 12'h070;
        return 12'((a * 13 + 7) % 4096);
    endfunction

    logic [11:0] spr_pipe [LAT];
    logic [11:0] gr_pipe  [LAT];
    always @(posedge clk) begin
        spr_pipe[0] <= spr_f(int'(spr_addr));
        gr_pipe[0]  <= grass_f(int'(grass_addr));
        for (int i = 1; i < LAT; i++) begin
            spr_pipe[i] <= spr_pipe[i-1];
            gr_pipe[i]  <= gr_pipe[i-1];
        end
    end
    assign spr_pixel   = spr_pipe[LAT-1];
    assign grass_pixel = gr_pipe[LAT-1];

    // Reference model state
    int m_x [NSEG];
    int m_y [NSEG];
    int m_len, ax, ay, wx, wy;
    int mmode = 0;
    int mcnt  = 0;

    function automatic bit hit(input int x, y, px, py);
        return x >= px && x < px + 32 && y >= py && y < py + 32;
    endfunction

    function automatic logic [11:0] model(input int x, y);
        int lay, px, py, n;
        bit h;
        if (x >= 1440 || y >= 900) return 12'h000;
        if (mmode == 1) return 12'h0F0;
        if (mmode == 2) return ((mcnt >> 4) & 1) ? 12'hF00 : grass_f(x + y * 1440);
        if (x < 16 || x >= 1424 || y < 16 || y >= 884) return 12'hFFF;
        h = 0; lay = 0; px = 0; py = 0;
        n = (m_len > NSEG) ? NSEG : m_len;
        if (hit(x, y, wx, wy)) begin
            h = 1; lay = 0; px = wx; py = wy;
        end else if (n >= 1 && hit(x, y, m_x[0], m_y[0])) begin
            h = 1; lay = 1; px = m_x[0]; py = m_y[0];
        end else begin
            for (int i = 1; i < n; i++)
                if (!h && hit(x, y, m_x[i], m_y[i])) begin
                    h = 1; lay = 2; px = m_x[i]; py = m_y[i];
                end
            if (!h && hit(x, y, ax, ay)) begin
                h = 1; lay = 3; px = ax; py = ay;
            end
        end
        if (h && spr_f(lay * 1024 + (x - px) + (y - py) * 32) != 12'h000)
            return spr_f(lay * 1024 + (x - px) + (y - py) * 32);
        return grass_f(x + y * 1440);
    endfunction

    typedef struct {
        int          due;
        logic [11:0] col;
    } exp_t;

    exp_t sbq [$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    logic [11:0] last_col = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_col = '0;
        end else if (draw_valid) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: cycle %0d colour %h", cyc,
                         {draw_r, draw_g, draw_b});
            end else begin
                e = sbq.pop_front();
                if (e.due != cyc || {draw_r, draw_g, draw_b} != e.col) begin
                    errors++;
                    $display("FAIL pixel: got %h at cycle %0d, expected %h at cycle %0d",
                             {draw_r, draw_g, draw_b}, cyc, e.col, e.due);
                end
            end
            last_col = {draw_r, draw_g, draw_b};
        end else begin
            checks++;
            if ({draw_r, draw_g, draw_b} != last_col) begin
                errors++;
                $display("FAIL hold: got %h expected %h", {draw_r, draw_g, draw_b}, last_col);
            end
            if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                errors++;
                $display("FAIL missing_valid: pixel due cycle %0d colour %h", e.due, e.col);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, record the expectation, advance the model.
    task automatic step(input bit v, input int x, input int y,
                        input bit fs, input bit w, input bit l);
        exp_t e;
        pix_valid   = v;
        curr_x      = CW'(x);
        curr_y      = CW'(y);
        frame_start = fs;
        win         = w;
        lose        = l;
        for (int i = 0; i < NSEG; i++) begin
            snakepos_x[i*CW +: CW] = CW'(m_x[i]);
            snakepos_y[i*CW +: CW] = CW'(m_y[i]);
        end
        length     = LW'(m_len);
        applepos_x = CW'(ax);
        applepos_y = CW'(ay);
        wallpos_x  = CW'(wx);
        wallpos_y  = CW'(wy);
        if (v && !rst) begin
            e.due = cyc + L;
            e.col = model(x, y);
            sbq.push_back(e);
        end
        if (fs && !rst) begin
            if (l && mmode != 2) mcnt = 0;
            else mcnt = (mcnt + 1) % 2048;
            mmode = l ? 2 : (w ? 1 : 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic park();
        for (int i = 0; i < NSEG; i++) begin
            m_x[i] = 2000;
            m_y[i] = 2000;
        end
        m_len = 0; ax = 2000; ay = 2000; wx = 2000; wy = 2000;
    endtask

    function automatic int near(input int v);
        int r;
        r = v - int'($urandom_range(0, 40));
        return (r < 0) ? 0 : r;
    endfunction

    initial begin
        int x, y;
        park();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", int'(draw_valid), 0);
        chk("reset_colour", int'({draw_r, draw_g, draw_b}), 0);
        chk("reset_spr_addr", int'(spr_addr), 0);
        chk("reset_grass_addr", int'(grass_addr), 0);
        rst = 1'b0;
        step(0, 0, 0, 0, 0, 0);

        // Wall beats segment 1 at the same spot
        m_len = 3; m_x[0] = 100; m_y[0] = 100; m_x[1] = 132; m_y[1] = 100;
        wx = 132; wy = 100; ax = 200; ay = 200;
        step(1, 140, 105, 0, 0, 0);
        chk("wall_spr_addr", int'(spr_addr), 168);
        // Apple with transparent sprite pixel falls back to grass
        wx = 2000; wy = 2000;
        step(1, 205, 210, 0, 0, 0);
        chk("apple_spr_addr", int'(spr_addr), 3397);
        chk("apple_grass_addr", int'(grass_addr), 302605);
        // Border beats head
        m_x[0] = 0; m_y[0] = 490;
        step(1, 5, 500, 0, 0, 0);
        step(1, 1440, 0, 0, 0, 0);
        // Bubble pattern
        step(1, 300, 300, 0, 0, 0);
        step(0, 301, 300, 0, 0, 0);
        step(1, 302, 300, 0, 0, 0);
        // No wrap of wall x + BLK near the top of the coordinate range
        wx = 2040; wy = 0;
        step(1, 2047, 5, 0, 0, 0);
        chk("wrap_spr_addr", int'(spr_addr), 167);
        park();
        step(0, 0, 0, 0, 0, 0);

        // Lose wins over win; blink after 16 frames; then win
        step(1, 300, 300, 1, 1, 1);
        for (int f = 0; f < 34; f++) begin
            step(1, 300 + f, 400, 0, 0, 0);
            step(1, 301 + f, 401, 1, 0, 1);
        end
        step(1, 500, 500, 1, 1, 0);
        step(1, 500, 501, 0, 0, 0);
        step(1, 500, 502, 1, 0, 0);
        step(1, 500, 503, 0, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            bit v, fs;
            x = $urandom_range(0, 1500);
            y = $urandom_range(0, 960);
            m_len = $urandom_range(0, 25);
            for (int i = 0; i < NSEG; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    m_x[i] = near(x); m_y[i] = near(y);
                end else begin
                    m_x[i] = $urandom_range(0, 2047); m_y[i] = $urandom_range(0, 2047);
                end
            end
            if ($urandom_range(0, 2) == 0) begin ax = near(x); ay = near(y); end
            else begin ax = $urandom_range(0, 2047); ay = $urandom_range(0, 2047); end
            if ($urandom_range(0, 5) == 0) begin wx = near(x); wy = near(y); end
            else begin wx = 2000; wy = 2000; end
            v  = ($urandom_range(0, 99) < 85);
            fs = ($urandom_range(0, 19) == 0);
            step(v, x, y, fs, 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 3) == 0));
            if (n == 700) begin
                // Mid-stream reset with pixels in flight
                step(1, 300, 300, 0, 0, 0);
                rst = 1'b1;
                #1;
                chk("midrst_valid", int'(draw_valid), 0);
                chk("midrst_colour", int'({draw_r, draw_g, draw_b}), 0);
                sbq.delete();
                mmode = 0;
                mcnt  = 0;
                park();
                @(posedge clk);
                #1;
                step(1, 320, 320, 0, 0, 0);
                step(1, 321, 320, 0, 0, 0);
                pix_valid = 1'b0;
                rst = 1'b0;
                step(0, 0, 0, 0, 0, 0);
                step(0, 0, 0, 0, 0, 0);
                step(1, 400, 400, 0, 0, 0);
            end
        end

        for (int k = 0; k < 50 && sbq.size() > 0; k++)
            step(0, 0, 0, 0, 0, 0);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pixels never emerged, expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
